skid_buffer: RTL and testbench

- Two-entry valid/ready register slice that sits directly downstream of the 8-bit flop stage and consumes its registered byte stream.
- Breaks the combinational ready path between producer and consumer.
- Sustains one transfer per cycle.
- Holds the output stable under backpressure without losing data.

---
 rtl/skid_buffer.sv | 173 +++++++++++++++++
 tb/tb_skid_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//
// Two-entry valid/ready register slice. It sits directly downstream of the
// 8-bit flop stage and consumes that stage's registered byte stream. It
// registers both in_ready and out_valid, so no combinational path runs from
// either side's handshake to the other. It sustains one word per cycle, and
// the skid register catches the word that is in flight when the consumer
// stalls.
//
// Build option:
//   SKID_BUFFER_STATS_EN - when defined, adds the stall_count output: a
//                          16-bit saturating count of cycles where
//                          out_valid=1 and out_ready=0. When undefined, the
//                          port and its counter are absent.
//
// Ports:
//   clk         in   rising-edge clock for all state
//   reset       in   asynchronous active-high reset, clears all state
//   in_valid    in   upstream word is valid
//   in_ready    out  registered; buffer can take a word this cycle
//   in_data     in   upstream word, DATA_W bits
//   out_valid   out  registered; out_data holds a valid word
//   out_ready   in   downstream takes out_data this cycle
//   out_data    out  registered output word, DATA_W bits
//   stall_count out  (SKID_BUFFER_STATS_EN only) saturating stall counter
//
// States:
//   state | meaning
//   EMPTY | no word held; in_ready=1, out_valid=0
//   BUSY  | main holds one word; in_ready=1, out_valid=1
//   FULL  | main and skid both hold words; in_ready=0, out_valid=1
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t            state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] main_q,      main_d;
    logic [DATA_W-1:0] skid_q,      skid_d;

    logic in_xfer;
    logic out_xfer;

    // The handshake terms use only registered outputs. Upstream offers made
    // while in_ready is low therefore cannot change anything.
    assign in_xfer  = in_valid    && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        main_d      = main_q;
        skid_d      = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d      = in_data;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b1;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    // Consumer stalled while a new word arrived. Park the new
                    // word in the skid register so main stays stable.
                    skid_d     = in_data;
                    in_ready_d = 1'b0;
                    state_d    = FULL;
                end else if (out_xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = EMPTY;
                end
            end

            FULL: begin
                // in_ready is low here, so the only event that matters is
                // the consumer draining main. The skid word is presented next.
                if (out_xfer) begin
                    main_d     = skid_q;
                    in_ready_d = 1'b1;
                    state_d    = BUSY;
                end
            end

            default: begin
                state_d     = EMPTY;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef SKID_BUFFER_STATS_EN
    // -------------------------------------------------------------------------
    // Stall counter: counts cycles where a valid word is held back by the
    // consumer. It saturates rather than wrapping, so a long stall never
    // reads as a short one.
    // -------------------------------------------------------------------------
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (out_valid_q && !out_ready && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
module tb_skid_buffer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef SKID_BUFFER_STATS_EN
    logic [15:0] stall_count;
`endif

    int tests_run;
    int tests_failed;

    skid_buffer #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SKID_BUFFER_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // 1. Reset held with an offer on the input.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid_t0", {15'd0, out_valid}, 16'h0000);
        check("rst_in_ready_t0",  {15'd0, in_ready},  16'h0001);
        check("rst_out_data_t0",  {8'd0, out_data},   16'h0000);
        step();
        step();
        check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("rst_in_ready",  {15'd0, in_ready},  16'h0001);
        check("rst_out_data",  {8'd0, out_data},   16'h0000);
        reset    = 1'b0;
        in_valid = 1'b0;

        // 2. Single transfer of 0x0F.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        step();
        in_valid = 1'b0;
        check("single_out_valid", {15'd0, out_valid}, 16'h0001);
        check("single_out_data",  {8'd0, out_data},   16'h000F);
        check("single_in_ready",  {15'd0, in_ready},  16'h0001);
        step();
        check("single_drained", {15'd0, out_valid}, 16'h0000);

        // Mid-cycle reset clears outputs before the next edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        step();
        in_valid = 1'b0;
        check("midrst_loaded", {8'd0, out_data}, 16'h0033);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("midrst_out_data",  {8'd0, out_data},   16'h0000);
        check("midrst_in_ready",  {15'd0, in_ready},  16'h0001);
        step();
        reset = 1'b0;

        // 3. Back-to-back stream at full rate.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 8'(i);
            step();
            check("stream_out_valid", {15'd0, out_valid}, 16'h0001);
            check("stream_out_data",  {8'd0, out_data},   16'(i));
            check("stream_in_ready",  {15'd0, in_ready},  16'h0001);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", {15'd0, out_valid}, 16'h0000);

        // 4. Fill to FULL under backpressure, then drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        step();
        in_data = 8'hFE;
        step();
        check("full_in_ready",  {15'd0, in_ready},  16'h0000);
        check("full_out_valid", {15'd0, out_valid}, 16'h0001);
        check("full_out_data",  {8'd0, out_data},   16'h000F);
        in_data = 8'hAA;
        step();
        step();
        check("full_hold_in_ready", {15'd0, in_ready}, 16'h0000);
        check("full_hold_data",     {8'd0, out_data},  16'h000F);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_skid_data",  {8'd0, out_data},   16'h00FE);
        check("drain_in_ready",   {15'd0, in_ready},  16'h0001);
        check("drain_out_valid",  {15'd0, out_valid}, 16'h0001);
        step();
        check("drain_no_aa", {15'd0, out_valid}, 16'h0000);

        // 5. Reset while FULL discards both words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        step();
        in_data = 8'hFE;
        step();
        in_valid = 1'b0;
        check("refull_in_ready", {15'd0, in_ready}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("fullrst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("fullrst_in_ready",  {15'd0, in_ready},  16'h0001);
        check("fullrst_out_data",  {8'd0, out_data},   16'h0000);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        step();
        in_valid = 1'b0;
        check("post_rst_data",  {8'd0, out_data},   16'h0055);
        check("post_rst_valid", {15'd0, out_valid}, 16'h0001);
        step();
        check("post_rst_no_stale", {15'd0, out_valid}, 16'h0000);

`ifdef SKID_BUFFER_STATS_EN
        // 6. Stall counter.
        check("stall_zero", stall_count, 16'h0000);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        step();
        in_valid = 1'b0;
        check("stall_none_yet", stall_count, 16'h0000);
        repeat (5) step();
        check("stall_five", stall_count, 16'h0005);
        repeat (70000) @(posedge clk);
        #1;
        check("stall_saturate", stall_count, 16'hFFFF);
        check("stall_data_held", {8'd0, out_data}, 16'h0077);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
